// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC controller handling sequential advance, redirects, stalls and halt.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] newPC,
  output logic        pc_valid,
  output logic        flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] redirect_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  state_t st, st_nx;
  logic [3:0] cnt, cnt_nx;
  logic [31:0] pc_nx, tgt;
  logic valid_nx, flush_nx, redir, stall_hold;
  logic [15:0] stall_nx, redir_nx;
  assign state = st;
  assign redir = st != BOOT && (br_taken || jmp);
  assign tgt = br_taken ? br_target : jmp_target;
  assign stall_hold = st == RUN && !redir && !halt_req && stall;
  always_ff @(posedge CLK)
    if (RST) st <= BOOT;
    else st <= st_nx;
  always_comb
    st_nx = st == BOOT ? RUN :
            redir ? FLUSH :
            st == RUN ? (halt_req ? HALT : RUN) :
            st == FLUSH ? (cnt == 4'd0 ? RUN : FLUSH) :
            (resume ? RUN : HALT);
  always_comb begin
    pc_nx = redir ? tgt :
            (st == FLUSH || (st == RUN && !halt_req && !stall)) ? newPC + PC_STEP : newPC;
    valid_nx = st == BOOT || redir ||
               (st == RUN ? (!halt_req && (stall ? pc_valid : 1'b1)) :
                st == FLUSH ? 1'b1 : resume);
    flush_nx = st_nx == FLUSH;
    cnt_nx = redir ? FLUSH_LOAD : (st == FLUSH && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    stall_nx = stall_hold && stall_cnt != 16'hFFFF ? stall_cnt + 16'd1 : stall_cnt;
    redir_nx = redir && redirect_cnt != 16'hFFFF ? redirect_cnt + 16'd1 : redirect_cnt;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      newPC <= RESET_VECTOR;
      pc_valid <= 1'b0;
      flush <= 1'b0;
      cnt <= 4'd0;
      stall_cnt <= 16'd0;
      redirect_cnt <= 16'd0;
    end else begin
      newPC <= pc_nx;
      pc_valid <= valid_nx;
      flush <= flush_nx;
      cnt <= cnt_nx;
      stall_cnt <= stall_nx;
      redirect_cnt <= redir_nx;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of pc_sequencer, plus a wrap-around instance.
module tb_pc_sequencer;
  logic CLK = 0, RST = 0, stall = 0, br_taken = 0, jmp = 0, halt_req = 0, resume = 0;
  logic [31:0] br_target = 0, jmp_target = 0;
  logic [31:0] newPC, w_pc;
  logic pc_valid, flush, w_valid, w_flush;
  logic [1:0] state, w_state;
  logic [15:0] stall_cnt, redirect_cnt, w_stall, w_redir;
  int total = 0, bad = 0;

  pc_sequencer dut (.CLK(CLK), .RST(RST), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .halt_req(halt_req), .resume(resume), .newPC(newPC),
    .pc_valid(pc_valid), .flush(flush), .state(state), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt));

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8)) wdut (.CLK(CLK), .RST(RST), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target), .halt_req(halt_req), .resume(resume),
    .newPC(w_pc), .pc_valid(w_valid), .flush(w_flush), .state(w_state), .stall_cnt(w_stall), .redirect_cnt(w_redir));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1; tick(); tick();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (newPC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", newPC); end
    total++; if (pc_valid !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", pc_valid, flush); end
    total++; if (stall_cnt !== 16'd0 || redirect_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnts got=%h/%h exp=0/0", stall_cnt, redirect_cnt); end
    RST = 0;
  endtask

  task automatic test_boot_run();
    tick();
    total++; if (state !== 2'd1 || newPC !== 32'h0 || pc_valid !== 1'b1) begin bad++; $display("FAIL boot_exit got=%0d/%h/%b exp=1/0/1", state, newPC, pc_valid); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (newPC !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc got=%h exp=%h", newPC, 32'(4 * i)); end
    end
  endtask

  task automatic test_stall();
    tick();
    total++; if (newPC !== 32'h10) begin bad++; $display("FAIL pre_stall got=%h exp=10", newPC); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (newPC !== 32'h10 || pc_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got=%h/%b exp=10/1", newPC, pc_valid); end
    end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
    stall = 0; tick();
    total++; if (newPC !== 32'h14) begin bad++; $display("FAIL post_stall got=%h exp=14", newPC); end
  endtask

  task automatic test_redirect();
    tick(); tick(); tick();
    total++; if (newPC !== 32'h20) begin bad++; $display("FAIL pre_redir got=%h exp=20", newPC); end
    br_taken = 1; br_target = 32'h100; jmp = 1; jmp_target = 32'h200; stall = 1;
    tick();
    br_taken = 0; jmp = 0;
    total++; if (newPC !== 32'h100 || flush !== 1'b1 || state !== 2'd2) begin bad++; $display("FAIL redir_first got=%h/%b/%0d exp=100/1/2", newPC, flush, state); end
    total++; if (redirect_cnt !== 16'd1) begin bad++; $display("FAIL redir_cnt1 got=%0d exp=1", redirect_cnt); end
    tick();
    total++; if (newPC !== 32'h104 || flush !== 1'b1) begin bad++; $display("FAIL redir_second got=%h/%b exp=104/1", newPC, flush); end
    tick();
    stall = 0;
    total++; if (newPC !== 32'h108 || flush !== 1'b0 || state !== 2'd1 || pc_valid !== 1'b1) begin bad++; $display("FAIL redir_done got=%h/%b/%0d/%b exp=108/0/1/1", newPC, flush, state, pc_valid); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL flush_stall_ignored got=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_restart();
    br_taken = 1; br_target = 32'h200; tick();
    br_target = 32'h40; tick();
    br_taken = 0;
    total++; if (newPC !== 32'h40 || flush !== 1'b1 || redirect_cnt !== 16'd3) begin bad++; $display("FAIL restart got=%h/%b/%0d exp=40/1/3", newPC, flush, redirect_cnt); end
    tick();
    total++; if (newPC !== 32'h44 || flush !== 1'b1) begin bad++; $display("FAIL restart_ext got=%h/%b exp=44/1", newPC, flush); end
    tick();
    total++; if (newPC !== 32'h48 || flush !== 1'b0 || state !== 2'd1) begin bad++; $display("FAIL restart_end got=%h/%b/%0d exp=48/0/1", newPC, flush, state); end
  endtask

  task automatic test_halt();
    tick();
    halt_req = 1; tick();
    total++; if (state !== 2'd3 || pc_valid !== 1'b0 || newPC !== 32'h4C) begin bad++; $display("FAIL halt_enter got=%0d/%b/%h exp=3/0/4c", state, pc_valid, newPC); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (newPC !== 32'h4C || pc_valid !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL halt_hold got=%h/%b/%b exp=4c/0/0", newPC, pc_valid, flush); end
    end
    resume = 1; tick();
    resume = 0; halt_req = 0;
    total++; if (state !== 2'd1 || newPC !== 32'h4C || pc_valid !== 1'b1) begin bad++; $display("FAIL resume got=%0d/%h/%b exp=1/4c/1", state, newPC, pc_valid); end
    tick();
    total++; if (newPC !== 32'h50) begin bad++; $display("FAIL post_resume got=%h exp=50", newPC); end
    halt_req = 1; tick();
    halt_req = 0; jmp = 1; jmp_target = 32'h80; tick();
    jmp = 0;
    total++; if (state !== 2'd2 || newPC !== 32'h80 || flush !== 1'b1 || pc_valid !== 1'b1) begin bad++; $display("FAIL halt_jmp got=%0d/%h/%b/%b exp=2/80/1/1", state, newPC, flush, pc_valid); end
    total++; if (redirect_cnt !== 16'd4) begin bad++; $display("FAIL redir_cnt4 got=%0d exp=4", redirect_cnt); end
  endtask

  task automatic test_reset_flush();
    br_taken = 1; br_target = 32'h500; tick();
    br_taken = 0;
    RST = 1; tick();
    total++; if (state !== 2'd0 || flush !== 1'b0 || pc_valid !== 1'b0 || newPC !== 32'h0) begin bad++; $display("FAIL rst_flush got=%0d/%b/%b/%h exp=0/0/0/0", state, flush, pc_valid, newPC); end
    total++; if (stall_cnt !== 16'd0 || redirect_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnts got=%h/%h exp=0/0", stall_cnt, redirect_cnt); end
    total++; if (w_pc !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_reset got=%h exp=fffffff8", w_pc); end
    RST = 0; tick();
    total++; if (state !== 2'd1 || flush !== 1'b0 || newPC !== 32'h0) begin bad++; $display("FAIL rst_discard got=%0d/%b/%h exp=1/0/0", state, flush, newPC); end
  endtask

  task automatic test_wrap();
    total++; if (w_pc !== 32'hFFFF_FFF8 || w_valid !== 1'b1) begin bad++; $display("FAIL wrap_boot got=%h/%b exp=fffffff8/1", w_pc, w_valid); end
    tick();
    total++; if (w_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_fc got=%h exp=fffffffc", w_pc); end
    tick();
    total++; if (w_pc !== 32'h0 || w_flush !== 1'b0 || w_state !== 2'd1) begin bad++; $display("FAIL wrap_zero got=%h/%b/%0d exp=0/0/1", w_pc, w_flush, w_state); end
  endtask

  task automatic test_saturate();
    stall = 1;
    repeat (65540) tick();
    stall = 0;
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL stall_sat got=%h exp=ffff", stall_cnt); end
    total++; if (newPC !== 32'h8 || w_stall !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h/%h exp=8/ffff", newPC, w_stall); end
  endtask

  initial begin
    test_reset();
    test_boot_run();
    test_stall();
    test_redirect();
    test_restart();
    test_halt();
    test_reset_flush();
    test_wrap();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter controller for the fetch stage. It owns the PC register and drives newPC into the fetch block every cycle. It selects between sequential advance, branch/jump redirect, hazard stall and halt, and generates the flush to kill wrong-path instructions. It sits between the hazard/branch-resolution logic and the instruction-fetch stage.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset
PC_STEP, 32'd4, sequential increment per fetch
FLUSH_CYCLES, 2, cycles flush stays asserted after a redirect (legal range 1..15)

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  synchronous reset, active-high
stall  input  1  hazard unit requests PC hold
br_taken  input  1  resolved branch taken
br_target  input  32  branch target address
jmp  input  1  jump request
jmp_target  input  32  jump target address
halt_req  input  1  request fetch halt
resume  input  1  leave HALT
newPC  output  32  registered PC presented to fetch
pc_valid  output  1  newPC is a real fetch, not a bubble
flush  output  1  kill IF/ID contents (wrong path)
state  output  2  0=BOOT 1=RUN 2=FLUSH 3=HALT
stall_cnt  output  16  cycles held by stall, saturating
redirect_cnt  output  16  accepted redirects, saturating

Behaviour:
- All outputs registered; inputs sampled at posedge, effect visible after that edge.
- Reset (RST=1 at posedge, any state): newPC=RESET_VECTOR, pc_valid=0, flush=0, state=BOOT, flush counter=0, stall_cnt=0, redirect_cnt=0. Mid-operation reset discards pending flush/halt.
- Priority per cycle: RST > br_taken > jmp > halt_req > stall > sequential.
- BOOT: one cycle only. newPC held at RESET_VECTOR, pc_valid<=1, ->RUN. Inputs ignored.
- Redirect (br_taken or jmp, in RUN, FLUSH or HALT): newPC<=selected target (br_target if both set), pc_valid<=1, flush<=1, counter<=FLUSH_CYCLES-1, redirect_cnt+1, ->FLUSH. Target used unmodified.
- RUN, no redirect:
  - halt_req: newPC held, pc_valid<=0, ->HALT.
  - else stall: newPC held, pc_valid unchanged, stall_cnt+1.
  - else newPC<=newPC+PC_STEP, pc_valid<=1.
- FLUSH: flush=1. stall and halt_req ignored. newPC advances by PC_STEP each cycle. Counter decrements. When counter==0 at the edge: flush<=0, ->RUN. New redirect in FLUSH reloads the counter and target (restart).
- HALT: newPC held, pc_valid=0, flush=0. resume (no redirect): pc_valid<=1, newPC unchanged (refetch the held PC), ->RUN. halt_req and resume both high: resume wins. Redirect exits HALT directly to FLUSH.
- Arithmetic: newPC+PC_STEP is modulo 2^32 (0xFFFF_FFFC+4 -> 0x0000_0000, no flag).
- Counters saturate at 16'hFFFF and never wrap. stall_cnt counts only RUN-state stall holds.

Test Plan:
- Reset then run, no inputs: cycle after RST falls state=BOOT, newPC=0, pc_valid=0. Next cycle RUN, newPC=0, pc_valid=1. Then 4, 8, 12.
- In RUN at newPC=0x10, assert stall 3 cycles: newPC stays 0x10 for 3 cycles, stall_cnt=3. Next newPC=0x14.
- At newPC=0x20, br_taken=1, br_target=0x100, jmp=1, jmp_target=0x200 in the same cycle: newPC=0x100, flush=1 for exactly 2 cycles (0x100, 0x104), then RUN at 0x108, redirect_cnt=1. Stall during the flush has no effect.
- In FLUSH (counter=1), second br_taken to 0x40: newPC=0x40, flush extended 2 more cycles, redirect_cnt=2.
- halt_req at newPC=0x30: HALT, pc_valid=0, newPC=0x30 held 5 cycles. resume -> RUN, newPC=0x30 pc_valid=1, then 0x34. Separately, jmp to 0x80 while in HALT -> FLUSH at 0x80.
- RESET_VECTOR=0xFFFF_FFF8: sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Assert RST during FLUSH: next state BOOT, flush=0, counters 0.
